shift_op_pipe: RTL and testbench

Pipelined, handshaked front end for the 8-bit multifunction barrel shifter. Accepts shift commands (data, amount, operation) over a valid/ready interface, converts every operation into a rotate-right performed by the existing combinational `right_shifter` core, and returns registered results downstream with backpressure. It sits between the command source and the result consumer, making the shifter usable in a streaming datapath at one result per cycle.

---
 rtl/shifter_pkg.sv | 37 +++
 rtl/right_shifter.sv | 14 +
 rtl/shift_op_pipe.sv | 113 +++++++++++
 tb/tb_shift_op_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the multifunction barrel shifter: op codes,
// default widths and the bit-reverse helper used by the pipe and its bench.
package shifter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_AMT_W = 3;
    localparam int MAX_W     = 64;
    localparam int MAX_AW    = 6;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_LSR = 2'b10;
    localparam logic [1:0] OP_LSL = 2'b11;

    // Reverses the low w bits of a; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] a,
                                                     input int w);
        logic [MAX_W-1:0]  r;
        logic [MAX_AW-1:0] idx;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            idx = MAX_AW'(w - 1 - i);
            if (i < w) begin
                r[i] = a[idx];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Left-going ops are executed as a right rotate on the mirrored operand.
    function automatic logic op_is_reversed(input logic [1:0] op);
        return (op == OP_ROL) || (op == OP_LSL);
    endfunction

endpackage

// File: rtl/right_shifter.sv
// Combinational rotate-right core shared by every shifter operation.
module right_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] y
);

    // Bits shifted out of the low half of {a,a} reappear at the top.
    assign y = WIDTH'({a, a} >> amt);

endmodule

// File: rtl/shift_op_pipe.sv
// Two-stage elastic valid/ready pipe around right_shifter; maps ROR/ROL/LSR/LSL
// onto a single rotate-right with operand/result mirroring and masking.
module shift_op_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       pending
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [AMT_W-1:0] r_s1_amt;
    logic [1:0]       r_s1_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_s1_data;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_unrev;
    logic [WIDTH-1:0] w_ones;
    logic [WIDTH-1:0] w_result;

    assign w_ones    = {WIDTH{1'b1}};
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    // Mirror the operand on entry for left-going operations.
    always_comb begin
        w_s1_data = in_data;
        if (op_is_reversed(in_op)) begin
            w_s1_data = WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH));
        end else begin
            w_s1_data = in_data;
        end
    end

    // Stage 1 command register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {WIDTH{1'b0}};
            r_s1_amt   <= {AMT_W{1'b0}};
            r_s1_op    <= OP_ROR;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_s1_data;
            r_s1_amt   <= in_amt;
            r_s1_op    <= in_op;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    right_shifter #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_right_shifter (
        .a   (r_s1_data),
        .amt (r_s1_amt),
        .y   (w_rot)
    );

    // Un-mirror the rotated value and apply the logical-shift fill mask.
    always_comb begin
        w_unrev  = w_rot;
        w_result = w_rot;
        if (op_is_reversed(r_s1_op)) begin
            w_unrev = WIDTH'(bit_reverse(MAX_W'(w_rot), WIDTH));
        end else begin
            w_unrev = w_rot;
        end
        case (r_s1_op)
            OP_LSR:  w_result = w_unrev & (w_ones >> r_s1_amt);
            OP_LSL:  w_result = w_unrev & (w_ones << r_s1_amt);
            OP_ROR:  w_result = w_unrev;
            OP_ROL:  w_result = w_unrev;
            default: w_result = w_unrev;
        endcase
    end

    // Stage 2 result register; data only changes on load so it holds under stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= {WIDTH{1'b0}};
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_result;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign pending   = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};

endmodule

// File: tb/tb_shift_op_pipe.sv
// Directed self-checking bench for shift_op_pipe: op results, latency,
// backpressure/drain ordering and mid-flight reset.
module tb_shift_op_pipe;
    import shifter_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] pending;

    int n_tests;
    int n_fail;

    shift_op_pipe #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d,
                         input logic [2:0] a);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
    endtask

    // Issue one command into an empty pipe with out_ready high and check its result.
    task automatic run_one(input string tag, input logic [1:0] op, input logic [7:0] d,
                           input logic [2:0] a, input logic [7:0] exp);
        logic found;
        found = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, op, d, a);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 16'(found), 16'h1);
        check(tag, 16'(out_data), 16'(exp));
    endtask

    logic [1:0] cmd_op  [4];
    logic [7:0] cmd_dat [4];
    logic [2:0] cmd_amt [4];
    logic [7:0] cmd_exp [4];

    initial begin
        int  k;
        int  r;
        int  extra;
        logic acc;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, OP_ROR, 8'h00, 3'd0);

        // Reset state
        #12;
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_data",  16'(out_data),  16'h0);
        check("rst_pending",   16'(pending),   16'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 16'(in_ready), 16'h1);

        // Latency and pending profile: 0x06 ROR 1 -> 0x03
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, OP_ROR, 8'h06, 3'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_pend1", 16'(pending), 16'h1);
        check("lat_ov0",   16'(out_valid), 16'h0);
        @(negedge clk);
        check("lat_pend2", 16'(pending), 16'h1);
        check("lat_ov1",   16'(out_valid), 16'h1);
        check("lat_data",  16'(out_data), 16'h03);
        @(negedge clk);
        check("lat_pend3", 16'(pending), 16'h0);
        check("lat_ov2",   16'(out_valid), 16'h0);

        // Per-op vectors (0x81 ROR 1 = 1100_0000)
        run_one("ror81_1", OP_ROR, 8'h81, 3'd1, 8'hC0);
        run_one("rol81_1", OP_ROL, 8'h81, 3'd1, 8'h03);
        run_one("lsr81_3", OP_LSR, 8'h81, 3'd3, 8'h10);
        run_one("lsl81_3", OP_LSL, 8'h81, 3'd3, 8'h08);
        run_one("ror_a0",  OP_ROR, 8'hA5, 3'd0, 8'hA5);
        run_one("rol_a0",  OP_ROL, 8'hA5, 3'd0, 8'hA5);
        run_one("lsr_a0",  OP_LSR, 8'hA5, 3'd0, 8'hA5);
        run_one("lsl_a0",  OP_LSL, 8'hA5, 3'd0, 8'hA5);
        run_one("lslff_7", OP_LSL, 8'hFF, 3'd7, 8'h80);
        run_one("lsrff_7", OP_LSR, 8'hFF, 3'd7, 8'h01);
        run_one("rol01_7", OP_ROL, 8'h01, 3'd7, 8'h80);
        run_one("rorb4_5", OP_ROR, 8'hB4, 3'd5, 8'hA5);

        // Backpressure: four commands, consumer stalled then released
        cmd_op[0] = OP_ROR; cmd_dat[0] = 8'h12; cmd_amt[0] = 3'd4; cmd_exp[0] = 8'h21;
        cmd_op[1] = OP_LSR; cmd_dat[1] = 8'hF0; cmd_amt[1] = 3'd4; cmd_exp[1] = 8'h0F;
        cmd_op[2] = OP_LSL; cmd_dat[2] = 8'h0F; cmd_amt[2] = 3'd4; cmd_exp[2] = 8'hF0;
        cmd_op[3] = OP_ROL; cmd_dat[3] = 8'h80; cmd_amt[3] = 3'd1; cmd_exp[3] = 8'h01;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, cmd_op[0], cmd_dat[0], cmd_amt[0]);
        #1 check("bp_rdy0", 16'(in_ready), 16'h1);
        @(negedge clk);
        drive(1'b1, cmd_op[1], cmd_dat[1], cmd_amt[1]);
        #1 check("bp_rdy1", 16'(in_ready), 16'h1);
        @(negedge clk);
        drive(1'b1, cmd_op[2], cmd_dat[2], cmd_amt[2]);
        #1;
        check("bp_full_rdy",  16'(in_ready),  16'h0);
        check("bp_full_pend", 16'(pending),   16'h2);
        check("bp_full_ov",   16'(out_valid), 16'h1);
        check("bp_full_data", 16'(out_data),  16'(cmd_exp[0]));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_data", 16'(out_data), 16'(cmd_exp[0]));
            check("bp_hold_rdy",  16'(in_ready), 16'h0);
            check("bp_hold_pend", 16'(pending),  16'h2);
        end
        out_ready = 1'b1;
        #1 acc = in_valid && in_ready;
        k = 2;
        r = 1;
        for (int c = 0; c < 20 && r < 4; c++) begin
            @(negedge clk);
            if (acc) k++;
            if (out_valid) begin
                check("drain_data", 16'(out_data), 16'(cmd_exp[r]));
                r++;
            end
            if (k < 4) drive(1'b1, cmd_op[k], cmd_dat[k], cmd_amt[k]);
            else in_valid = 1'b0;
            #1 acc = in_valid && in_ready;
        end
        check("drain_count", 16'(r), 16'h4);
        @(negedge clk);
        check("drain_pend", 16'(pending),   16'h0);
        check("drain_ov",   16'(out_valid), 16'h0);

        // Reset with both stages occupied
        out_ready = 1'b0;
        drive(1'b1, OP_ROR, 8'h55, 3'd2);
        @(negedge clk);
        drive(1'b1, OP_LSL, 8'h33, 3'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("rr_pend_pre", 16'(pending), 16'h2);
        reset = 1'b1;
        #1;
        check("rr_ov",   16'(out_valid), 16'h0);
        check("rr_pend", 16'(pending),   16'h0);
        check("rr_data", 16'(out_data),  16'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rr_rdy", 16'(in_ready), 16'h1);
        run_one("rr_ror06", OP_ROR, 8'h06, 3'd1, 8'h03);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("rr_no_extra", 16'(extra), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
